mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Multi-cycle successor to the single-cycle control decoder. It is a registered FSM that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and holds memory accesses on a `MIO_ready` handshake with a bounded wait. Branches are resolved internally from ALU flags; the full RV32I branch set is optional. Illegal opcodes and bus timeouts trap. It sits between the instruction register/ALU flags and the shared-datapath enables of the multi-cycle CPU.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum wait cycles per memory access. 0 disables the timeout.
- `EXT_BRANCH`, 1: enables blt/bge/bltu/bgeu. When 0, they decode as illegal.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `OPcode` in 5: inst[6:2]. `Fun3` in 3. `Fun7` in 1: inst[30].
- `zero`, `lt`, `ltu` in 1 each: ALU compare flags, valid in EXEC.
- `MIO_ready` in 1: memory access complete.
- `mem_req` out 1. `MemRW` out 1: 1 = write.
- `IR_we`, `PC_we`, `RegWrite` out 1 each.
- `pc_sel` out 2: 00 = PC+4, 01 = PC+imm, 10 = ALU result.
- `ALUSrc_B` out 1. `MemtoReg` out 2: 00 = ALU, 01 = mem, 10 = PC+4, 11 = imm.
- `ImmSel` out 3: 000 = U, 001 = I, 010 = S, 011 = B, 100 = J.
- `ALU_Control` out 4. `trap` out 1. `trap_cause` out 2: 01 = illegal, 10 = bus timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding lives in the package.
- FETCH: `mem_req`=1 and `MemRW`=0. On `MIO_ready`, pulse `IR_we` and go to DECODE.
- DECODE: classify the instruction and latch the class into a registered decode word.
  - Unsupported OPcode, Fun3, or Fun3/Fun7 combination → TRAP with cause 01.
- EXEC: drive `ALU_Control`, `ALUSrc_B` and `ImmSel` from the latched class.
  - Branch: taken = beq:`zero`, bne:!`zero`, blt:`lt`, bge:!`lt`, bltu:`ltu`, bgeu:!`ltu`.
  - Branch: pulse `PC_we` with `pc_sel` = taken ? 01 : 00, then go to FETCH.
  - Load or store → MEM. All other classes → WB.
- MEM: `mem_req`=1, `MemRW`=store. On `MIO_ready`:
  - Load → WB.
  - Store → pulse `PC_we` (`pc_sel`=00), then go to FETCH.
- WB: pulse `RegWrite` and `PC_we`, then go to FETCH.
  - `pc_sel`=01 for jal, 10 for jalr, 00 otherwise.
  - `MemtoReg` per class: 01 load, 10 jal/jalr, 11 lui, 00 otherwise.
- ALU codes: add 0010, sub 0110, sll 1110, slt 0111, sltu 1001, xor 1100, srl 1101, sra 1111, or 0001, and 0000.
  - Branches use sub. Load, store, jalr and addi use add.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle `MIO_ready`=0.
  - When it reaches `MEM_TIMEOUT` (nonzero) → TRAP with cause 10.
  - Width is clog2(`MEM_TIMEOUT`+1).
- TRAP: `trap`=1, all enables 0, `trap_cause` held. Exit only through reset.

## Timing
- Reset: state=FETCH, counter=0. All outputs 0 except `mem_req`=1 (FETCH output). `trap`=0 and `trap_cause`=00.
- Outputs are Moore (decoded from the registered state and decode word), except `IR_we` and MEM exit, which are qualified by same-cycle `MIO_ready`.
- Cycles with zero wait: branch 3, ALU/lui/jal/jalr 4, store 4, load 5. Each wait cycle adds 1.
- `MIO_ready` high in the same cycle as the timeout count: ready wins, no trap.
- `rst_n` low mid-access: asynchronous return to reset values. A pending access is abandoned.
- `PC_we` is high for exactly one cycle per retired instruction.

## Structure
- Package `mcpu_pkg`: state enum, ALU code constants, ImmSel and MemtoReg codes, trap cause codes, instruction-class enum.
- Sub-module `mcpu_decode`: combinational class, ALU code and immediate decode, shared with the single-cycle path. The FSM instantiates it once.

## Test plan
- add (OPcode 01100, Fun3 000, Fun7 0), `MIO_ready` always 1:
  - `RegWrite` and `PC_we` pulse in cycle 4.
  - `ALU_Control`=0010 in EXEC.
- lw with `MIO_ready` low for 3 cycles in MEM:
  - WB occurs in cycle 8.
  - `MemtoReg`=01.
- bltu with `ltu`=1 (`EXT_BRANCH`=1):
  - `pc_sel`=01 and `PC_we` in cycle 3.
  - Same test with `EXT_BRANCH`=0 → `trap`=1, `trap_cause`=01.
- OPcode 11111 → TRAP after DECODE, with all enables held at 0 for 20 cycles.
- `MEM_TIMEOUT`=4 with `MIO_ready` stuck at 0 in FETCH → `trap_cause`=10 after 4 wait cycles. `rst_n` pulse then returns to FETCH with `mem_req`=1.
- Store with `MIO_ready` asserted on the timeout cycle → no trap, `PC_we`=1, and FETCH on the next cycle.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle control FSM and its decoder.
package mcpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU_R   = 4'd0,
    CL_ALU_I   = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_ILLEGAL = 4'd8
  } iclass_e;

  // Registered decode word captured in DECODE and consumed by EXEC/MEM/WB.
  typedef struct packed {
    iclass_e    cls;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       alu_src_b;
    logic [2:0] fun3;
  } dec_word_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_ALU_I  = 5'b00100;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ALU_R  = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0000;

  localparam logic [2:0] IMM_U = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;
  localparam logic [1:0] M2R_IMM = 2'b11;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_IMM = 2'b01;
  localparam logic [1:0] PCS_ALU = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  // ALU operation from funct3; alt selects sub/sra (inst[30]).
  function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_for = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_for = ALU_SLL;
      3'b010:  alu_for = ALU_SLT;
      3'b011:  alu_for = ALU_SLTU;
      3'b100:  alu_for = ALU_XOR;
      3'b101:  alu_for = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_for = ALU_OR;
      default: alu_for = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_decode.sv
// Combinational instruction classifier: class, ALU code, immediate type.
module mcpu_decode
  import mcpu_pkg::*;
#(
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic [4:0] opcode_i,
  input  logic [2:0] fun3_i,
  input  logic       fun7_i,
  output dec_word_t  dec_o
);

  logic bad;

  // Classify the opcode and reject unsupported funct3/funct7 combinations.
  always_comb begin
    bad           = 1'b0;
    dec_o.cls     = CL_ILLEGAL;
    dec_o.alu     = ALU_ADD;
    dec_o.imm     = IMM_U;
    dec_o.alu_src_b = 1'b0;
    dec_o.fun3    = fun3_i;
    case (opcode_i)
      OP_ALU_R: begin
        dec_o.cls = CL_ALU_R;
        dec_o.alu = alu_for(fun3_i, fun7_i);
        bad       = fun7_i && (fun3_i != 3'b000) && (fun3_i != 3'b101);
      end
      OP_ALU_I: begin
        // inst[30] is an immediate bit except for the shift-right pair.
        dec_o.cls       = CL_ALU_I;
        dec_o.alu       = alu_for(fun3_i, (fun3_i == 3'b101) && fun7_i);
        dec_o.imm       = IMM_I;
        dec_o.alu_src_b = 1'b1;
        bad             = (fun3_i == 3'b001) && fun7_i;
      end
      OP_LOAD: begin
        dec_o.cls       = CL_LOAD;
        dec_o.imm       = IMM_I;
        dec_o.alu_src_b = 1'b1;
        bad = (fun3_i == 3'b011) || (fun3_i == 3'b110) || (fun3_i == 3'b111);
      end
      OP_STORE: begin
        dec_o.cls       = CL_STORE;
        dec_o.imm       = IMM_S;
        dec_o.alu_src_b = 1'b1;
        bad             = (fun3_i > 3'b010);
      end
      OP_BRANCH: begin
        dec_o.cls = CL_BRANCH;
        dec_o.alu = ALU_SUB;
        dec_o.imm = IMM_B;
        bad = (fun3_i[2:1] == 2'b01) || (fun3_i[2] && !EXT_BRANCH);
      end
      OP_JAL: begin
        dec_o.cls = CL_JAL;
        dec_o.imm = IMM_J;
      end
      OP_JALR: begin
        dec_o.cls       = CL_JALR;
        dec_o.imm       = IMM_I;
        dec_o.alu_src_b = 1'b1;
        bad             = (fun3_i != 3'b000);
      end
      OP_LUI: begin
        dec_o.cls = CL_LUI;
      end
      default: bad = 1'b1;
    endcase
    if (bad) dec_o.cls = CL_ILLEGAL;
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a trapping TRAP state.
//
// Memory handshake: mem_req is a request held high for every cycle of an
// access; MIO_ready high in a cycle with mem_req high completes the access in
// that cycle. Nothing is transferred on a cycle where mem_req is low.
module mcpu_ctrl
  import mcpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter bit EXT_BRANCH  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       MIO_ready,
  output logic       mem_req,
  output logic       MemRW,
  output logic       IR_we,
  output logic       PC_we,
  output logic       RegWrite,
  output logic [1:0] pc_sel,
  output logic       ALUSrc_B,
  output logic [1:0] MemtoReg,
  output logic [2:0] ImmSel,
  output logic [3:0] ALU_Control,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] dbg_state_o
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  dec_word_t     dec_q, dec_d, dec_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          timeout, taken;

  mcpu_decode #(.EXT_BRANCH(EXT_BRANCH)) u_decode (
    .opcode_i (OPcode),
    .fun3_i   (Fun3),
    .fun7_i   (Fun7),
    .dec_o    (dec_w)
  );

  // The count value itself is the timeout cycle; ready in that cycle still wins.
  assign timeout     = (MEM_TIMEOUT != 0) && (cnt_q == TO_VAL);
  assign trap_cause  = cause_q;
  assign dbg_state_o = state_q;

  // Branch condition from the latched funct3 and the ALU compare flags.
  always_comb begin
    taken = 1'b0;
    case (dec_q.fun3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // State, decode word, wait counter and trap cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      dec_q   <= '0;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and Moore outputs; IR_we and MEM exit also follow MIO_ready.
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    cnt_d       = '0;
    cause_d     = cause_q;
    mem_req     = 1'b0;
    MemRW       = 1'b0;
    IR_we       = 1'b0;
    PC_we       = 1'b0;
    RegWrite    = 1'b0;
    pc_sel      = PCS_PC4;
    ALUSrc_B    = 1'b0;
    MemtoReg    = M2R_ALU;
    ImmSel      = IMM_U;
    ALU_Control = ALU_AND;
    trap        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (MIO_ready) begin
          IR_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          cause_d = CAUSE_BUS;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DECODE: begin
        dec_d = dec_w;
        if (dec_w.cls == CL_ILLEGAL) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ALU_Control = dec_q.alu;
        ALUSrc_B    = dec_q.alu_src_b;
        ImmSel      = dec_q.imm;
        if (dec_q.cls == CL_BRANCH) begin
          PC_we   = 1'b1;
          pc_sel  = taken ? PCS_IMM : PCS_PC4;
          state_d = ST_FETCH;
        end else if (dec_q.cls == CL_LOAD || dec_q.cls == CL_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        MemRW   = (dec_q.cls == CL_STORE);
        if (MIO_ready) begin
          if (dec_q.cls == CL_STORE) begin
            PC_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          cause_d = CAUSE_BUS;
          state_d = ST_TRAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PC_we    = 1'b1;
        state_d  = ST_FETCH;
        case (dec_q.cls)
          CL_JAL:  begin pc_sel = PCS_IMM; MemtoReg = M2R_PC4; end
          CL_JALR: begin pc_sel = PCS_ALU; MemtoReg = M2R_PC4; end
          CL_LOAD: MemtoReg = M2R_MEM;
          CL_LUI:  MemtoReg = M2R_IMM;
          default: MemtoReg = M2R_ALU;
        endcase
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: per-cycle expected output vectors.
module tb_mcpu_ctrl;
  import mcpu_pkg::*;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] OPcode = '0;
  logic [2:0] Fun3 = '0;
  logic       Fun7 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, MIO_ready = 1'b0;

  logic a_mem_req, a_MemRW, a_IR_we, a_PC_we, a_RegWrite, a_ALUSrc_B, a_trap;
  logic [1:0] a_pc_sel, a_MemtoReg, a_trap_cause;
  logic [2:0] a_ImmSel, a_dbg;
  logic [3:0] a_ALU_Control;
  logic b_mem_req, b_MemRW, b_IR_we, b_PC_we, b_RegWrite, b_ALUSrc_B, b_trap;
  logic [1:0] b_pc_sel, b_MemtoReg, b_trap_cause;
  logic [2:0] b_ImmSel, b_dbg;
  logic [3:0] b_ALU_Control;

  logic [W-1:0] vec_a, vec_b;
  logic [W-1:0] exp_q[$];
  int checks = 0, failures = 0, cyc_n = 0;
  bit sel_b = 1'b0;
  string cur_test = "";
  logic [W-1:0] e_fetch, e_frdy, e_idle, e_trap_ill, e_trap_bus;

  assign vec_a = {a_mem_req, a_MemRW, a_IR_we, a_PC_we, a_RegWrite, a_pc_sel, a_ALUSrc_B,
                  a_MemtoReg, a_ImmSel, a_ALU_Control, a_trap, a_trap_cause};
  assign vec_b = {b_mem_req, b_MemRW, b_IR_we, b_PC_we, b_RegWrite, b_pc_sel, b_ALUSrc_B,
                  b_MemtoReg, b_ImmSel, b_ALU_Control, b_trap, b_trap_cause};

  // Default parameters: 255-cycle timeout, extended branches on.
  mcpu_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
    .zero(zero), .lt(lt), .ltu(ltu), .MIO_ready(MIO_ready),
    .mem_req(a_mem_req), .MemRW(a_MemRW), .IR_we(a_IR_we), .PC_we(a_PC_we),
    .RegWrite(a_RegWrite), .pc_sel(a_pc_sel), .ALUSrc_B(a_ALUSrc_B),
    .MemtoReg(a_MemtoReg), .ImmSel(a_ImmSel), .ALU_Control(a_ALU_Control),
    .trap(a_trap), .trap_cause(a_trap_cause), .dbg_state_o(a_dbg)
  );

  // Short timeout, extended branches off.
  mcpu_ctrl #(.MEM_TIMEOUT(4), .EXT_BRANCH(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
    .zero(zero), .lt(lt), .ltu(ltu), .MIO_ready(MIO_ready),
    .mem_req(b_mem_req), .MemRW(b_MemRW), .IR_we(b_IR_we), .PC_we(b_PC_we),
    .RegWrite(b_RegWrite), .pc_sel(b_pc_sel), .ALUSrc_B(b_ALUSrc_B),
    .MemtoReg(b_MemtoReg), .ImmSel(b_ImmSel), .ALU_Control(b_ALU_Control),
    .trap(b_trap), .trap_cause(b_trap_cause), .dbg_state_o(b_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Output vector: mem_req MemRW IR_we PC_we RegWrite pc_sel ALUSrc_B MemtoReg ImmSel ALU trap cause
  function automatic logic [W-1:0] ov(input logic mreq, mrw, irwe, pcwe, rw,
                                      input logic [1:0] pcs, input logic asrc,
                                      input logic [1:0] m2r, input logic [2:0] imm,
                                      input logic [3:0] alu, input logic trp,
                                      input logic [1:0] cause);
    return {mreq, mrw, irwe, pcwe, rw, pcs, asrc, m2r, imm, alu, trp, cause};
  endfunction

  // Reset both DUTs and load the instruction fields for the next test.
  task automatic start_test(input string name, input logic [4:0] op, input logic [2:0] f3,
                            input logic f7, input bit use_b);
    rst_n = 1'b0;
    OPcode = op; Fun3 = f3; Fun7 = f7;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; MIO_ready = 1'b0;
    sel_b = use_b; cur_test = name; cyc_n = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle, push the expected vector, compare at the falling edge.
  task automatic cyc(input logic rdy, input logic [W-1:0] exp);
    MIO_ready = rdy;
    cyc_n++;
    exp_q.push_back(exp);
    @(negedge clk);
    check($sformatf("%s_c%0d", cur_test, cyc_n), sel_b ? vec_b : vec_a, exp_q.pop_front());
    @(posedge clk); #1;
  endtask

  initial begin
    e_fetch    = ov(1,0,0,0,0,2'b00,0,2'b00,3'b000,4'b0000,0,2'b00);
    e_frdy     = ov(1,0,1,0,0,2'b00,0,2'b00,3'b000,4'b0000,0,2'b00);
    e_idle     = '0;
    e_trap_ill = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,4'b0000,1,2'b01);
    e_trap_bus = ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,4'b0000,1,2'b10);

    // Reset values while rst_n is held low.
    @(negedge clk);
    check("rst_out_a", vec_a, e_fetch);
    check("rst_out_b", vec_b, e_fetch);
    check("rst_state", W'(a_dbg), W'(ST_FETCH));

    // add, no waits: RegWrite/PC_we in cycle 4.
    start_test("add", 5'b01100, 3'b000, 1'b0, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,4'b0010,0,2'b00));
    cyc(1, ov(0,0,0,1,1,2'b00,0,2'b00,3'b000,4'b0000,0,2'b00));
    cyc(1, e_frdy);

    // sub: R-type with inst[30] set.
    start_test("sub", 5'b01100, 3'b000, 1'b1, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,0,0,2'b00,0,2'b00,3'b000,4'b0110,0,2'b00));

    // lw with 3 wait cycles in MEM: WB in cycle 8.
    start_test("lw", 5'b00000, 3'b010, 1'b0, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,0,0,2'b00,1,2'b00,3'b001,4'b0010,0,2'b00));
    for (int i = 0; i < 3; i++) cyc(0, e_fetch);
    cyc(1, e_fetch);
    cyc(1, ov(0,0,0,1,1,2'b00,0,2'b01,3'b000,4'b0000,0,2'b00));

    // bltu taken with extended branches: PC_we, pc_sel=01 in cycle 3.
    start_test("bltu_ext", 5'b11000, 3'b110, 1'b0, 1'b0);
    ltu = 1'b1;
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,1,0,2'b01,0,2'b00,3'b011,4'b0110,0,2'b00));
    cyc(1, e_frdy);

    // Same bltu without extended branches: illegal trap.
    start_test("bltu_noext", 5'b11000, 3'b110, 1'b0, 1'b1);
    ltu = 1'b1;
    cyc(1, e_frdy);
    cyc(1, e_idle);
    for (int i = 0; i < 3; i++) cyc(1, e_trap_ill);
    check("bltu_noext_state", W'(b_dbg), W'(ST_TRAP));

    // beq not taken: PC+4.
    start_test("beq_nt", 5'b11000, 3'b000, 1'b0, 1'b0);
    zero = 1'b0;
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,1,0,2'b00,0,2'b00,3'b011,4'b0110,0,2'b00));

    // jal: J immediate in EXEC, PC+imm and PC+4 writeback in WB.
    start_test("jal", 5'b11011, 3'b000, 1'b0, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,0,0,2'b00,0,2'b00,3'b100,4'b0010,0,2'b00));
    cyc(1, ov(0,0,0,1,1,2'b01,0,2'b10,3'b000,4'b0000,0,2'b00));

    // Illegal R-type funct3/funct7 combination.
    start_test("r_bad", 5'b01100, 3'b001, 1'b1, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, e_trap_ill);

    // Illegal opcode: trap held for 20 cycles whatever the inputs do.
    start_test("op_bad", 5'b11111, 3'b000, 1'b0, 1'b0);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    for (int i = 0; i < 20; i++) begin
      zero = 1'($urandom_range(0, 1));
      lt   = 1'($urandom_range(0, 1));
      ltu  = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 1)), e_trap_ill);
    end

    // Fetch timeout with MEM_TIMEOUT=4: bus trap after the 4-wait count.
    start_test("fetch_to", 5'b01100, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, e_fetch);
    for (int i = 0; i < 3; i++) cyc(0, e_trap_bus);
    // Asynchronous reset pulse returns to FETCH immediately.
    rst_n = 1'b0;
    #2;
    check("rst_pulse_out", vec_b, e_fetch);
    check("rst_pulse_state", W'(b_dbg), W'(ST_FETCH));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur_test = "after_rst"; cyc_n = 0;
    cyc(0, e_fetch);

    // Store with ready arriving exactly on the timeout cycle: retires.
    start_test("sw_to", 5'b01000, 3'b010, 1'b0, 1'b1);
    cyc(1, e_frdy);
    cyc(1, e_idle);
    cyc(1, ov(0,0,0,0,0,2'b00,1,2'b00,3'b010,4'b0010,0,2'b00));
    for (int i = 0; i < 4; i++) cyc(0, ov(1,1,0,0,0,2'b00,0,2'b00,3'b000,4'b0000,0,2'b00));
    cyc(1, ov(1,1,0,1,0,2'b00,0,2'b00,3'b000,4'b0000,0,2'b00));
    cyc(0, e_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
